icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache that sits between the fetch stage and the instruction memory.
- Acts as the responder for the fetch-side word-address read interface.
- Returns a 32-bit instruction word on a hit in the same cycle. On a miss it holds stall high while it refills a 4-word line from memory.
- Also keeps hit and miss counters for performance bring-up.

Parameters:
NUM_BLOCKS, 8, number of cache lines; power of two, minimum 2; INDEX_W = log2(NUM_BLOCKS)
ADDR_W, 30, processor word-address width
TAG_W, ADDR_W-2-INDEX_W (default 25), derived, not overridable

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
proc_read  input  1  fetch read request
proc_write  input  1  fetch write request; unsupported, ignored (fetch drives 0)
proc_addr  input  ADDR_W  word address; [1:0]=word offset, [INDEX_W+1:2]=index, upper bits=tag
proc_wdata  input  32  ignored
proc_rdata  output  32  instruction word, valid when proc_read && !proc_stall
proc_stall  output  1  high while the request cannot be served this cycle
mem_read  output  1  line-fill request to memory
mem_write  output  1  constant 0
mem_addr  output  ADDR_W-2  line address {tag,index} being filled
mem_rdata  input  128  line data; word k = mem_rdata[32k+31:32k]
mem_ready  input  1  one-cycle pulse, mem_rdata valid in that cycle
hit_count  output  32  saturating count of served hits
miss_count  output  32  saturating count of misses (line fills started)

Behaviour:
- Storage per line: valid bit, TAG_W tag, 128-bit data. Registers only; no SRAM macro.
- Reset (rst=1 at an edge), regardless of state:
  - All valid bits cleared; state goes to IDLE.
  - hit_count and miss_count go to 0.
  - Tags and data are not reset.
- Outputs during and after reset: mem_read=0, proc_stall=0 (when proc_read=0), proc_rdata=0.
- hit = valid[index] && tag[index]==proc_addr tag.
- FSM has two states, IDLE and FETCH.
- IDLE:
  - proc_read=0: proc_stall=0, proc_rdata=0, nothing changes.
  - proc_read && hit: proc_stall=0 and proc_rdata = selected word, both combinationally in the same cycle; hit_count increments. Hit latency is 0 cycles.
  - proc_read && !hit: proc_stall=1. At the next edge: latch {tag,index} into the mem_addr register, set mem_read, increment miss_count, go to FETCH.
- FETCH:
  - proc_stall=1, mem_read=1, mem_addr held stable until mem_ready.
  - On mem_ready: write mem_rdata into the data of the latched index, write the latched tag, set valid; mem_read drops at the edge; go to IDLE.
  - The next cycle re-evaluates as a hit. Minimum miss penalty is 2 cycles plus memory latency.
- Fill completion: a fill is never aborted. If proc_read drops or proc_addr changes during FETCH, the fill still completes into the latched line. The new address is evaluated in IDLE afterwards.
- Eviction: a fill into an already-valid index overwrites it silently. No write-back is needed because the cache is read-only.
- mem_ready while in IDLE is ignored.
- proc_write is ignored: no state change, never stalls on its own.
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- hit_count increments once per cycle of proc_read && hit in IDLE. The post-fill replay therefore counts as one hit; a request that missed counts once as a miss and once as a hit.
- proc_rdata when proc_read=0 or proc_stall=1 is 0.

Test Plan:
- Reset, then proc_read=1, addr=0x0000_0004 -> proc_stall=1.
  - Next cycle: mem_read=1, mem_addr=0x000_0001.
  - mem_ready with mem_rdata = {0xDDDD_DDDD, 0xCCCC_CCCC, 0xBBBB_BBBB, 0xAAAA_AAAA} -> next cycle stall=0, rdata=0xAAAA_AAAA; miss_count=1, hit_count=1.
- After that fill, addresses 0x05, 0x06, 0x07 on consecutive cycles -> stall=0 each cycle; rdata=0xBBBB_BBBB, 0xCCCC_CCCC, 0xDDDD_DDDD; hit_count=4.
- Conflict:
  - Fill addr 0x04, then read addr 0x24 (same index 1, different tag) -> miss, mem_addr=0x009; old line evicted.
  - Then read 0x04 -> miss again; miss_count=3.
- In FETCH, drop proc_read and change addr to 0x40 before mem_ready -> mem_addr stays 0x001 and the fill completes.
  - proc_read=1 on 0x40 then triggers a new miss with mem_addr=0x010.
- Assert rst for one cycle mid-FETCH -> mem_read=0 next cycle, counters 0.
  - A later read of the previously filled address misses.
- proc_write=1, proc_read=0, any addr -> stall=0, mem_read stays 0, counters unchanged.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with 4-word lines; it answers
// fetch reads in the same cycle on a hit and stalls the fetch stage through a line refill.
module icache_responder #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_W     = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                proc_read,
  input  logic                proc_write,
  input  logic [ADDR_W-1:0]   proc_addr,
  input  logic [31:0]         proc_wdata,
  output logic [31:0]         proc_rdata,
  output logic                proc_stall,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-3:0]   mem_addr,
  input  logic [127:0]        mem_rdata,
  input  logic                mem_ready,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
);

  localparam int INDEX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W   = ADDR_W - 2 - INDEX_W;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t                state_q, state_d;

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [127:0]          data_q [NUM_BLOCKS];
  logic [ADDR_W-3:0]     fill_addr_q;
  logic [31:0]           hit_q, miss_q;

  logic [TAG_W-1:0]      req_tag;
  logic [INDEX_W-1:0]    req_idx;
  logic [1:0]            req_off;
  logic [TAG_W-1:0]      fill_tag;
  logic [INDEX_W-1:0]    fill_idx;
  logic [127:0]          sel_line;
  logic [31:0]           sel_word;
  logic                  hit;
  logic                  hit_evt, miss_evt, fill_done;
  logic                  unused;

  // Writes are not supported on the fetch port; keep the inputs for drop-in compatibility.
  assign unused = ^{proc_write, proc_wdata};

  assign req_off  = proc_addr[1:0];
  assign req_idx  = proc_addr[INDEX_W+1:2];
  assign req_tag  = proc_addr[ADDR_W-1:INDEX_W+2];
  assign fill_idx = fill_addr_q[INDEX_W-1:0];
  assign fill_tag = fill_addr_q[ADDR_W-3:INDEX_W];

  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign sel_line = data_q[req_idx];
  assign sel_word = sel_line[{req_off, 5'd0} +: 32];

  assign fill_done  = (state_q == FETCH) && mem_ready;
  assign mem_read   = (state_q == FETCH);
  assign mem_write  = 1'b0;
  assign mem_addr   = fill_addr_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (proc_read) begin
          if (hit) begin
            proc_rdata = sel_word;
            hit_evt    = 1'b1;
          end else begin
            proc_stall = 1'b1;
            miss_evt   = 1'b1;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        // The fill always runs to completion, whatever the fetch side does meanwhile.
        proc_stall = 1'b1;
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      fill_addr_q <= '0;
      hit_q       <= '0;
      miss_q      <= '0;
    end else begin
      state_q <= state_d;
      if (miss_evt) fill_addr_q <= proc_addr[ADDR_W-1:2];
      if (fill_done) valid_q[fill_idx] <= 1'b1;
      if (hit_evt && (hit_q != '1)) hit_q <= hit_q + 32'd1;
      if (miss_evt && (miss_q != '1)) miss_q <= miss_q + 32'd1;
    end
  end

  // Tag and data arrays carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!rst && fill_done) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// Directed bench for icache_responder: fills, hits, conflicts, fill completion, reset and ignored inputs.
module tb_icache_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic [31:0]  hit_count, miss_count;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE_A = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
  localparam logic [127:0] LINE_B = {32'h2424_0003, 32'h2424_0002, 32'h2424_0001, 32'h2424_0000};
  localparam logic [127:0] LINE_C = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

  icache_responder #(.NUM_BLOCKS(8), .ADDR_W(30)) dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
    .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_respond(input logic [127:0] line);
    mem_ready = 1'b1;
    mem_rdata = line;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; proc_read = 1'b0; proc_write = 1'b0; proc_addr = '0;
    proc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL reset_mem_read got=%b exp=0", mem_read); end
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", proc_stall); end
    total++; if (proc_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", proc_rdata); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL reset_hits got=%0d exp=0", hit_count); end
    total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL reset_misses got=%0d exp=0", miss_count); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
  endtask

  task automatic test_miss_fill();
    proc_read = 1'b1; proc_addr = 30'h4; #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL miss_stall got=%b exp=1", proc_stall); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL miss_mem_read_early got=%b exp=0", mem_read); end
    tick();
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL fetch_mem_read got=%b exp=1", mem_read); end
    total++; if (mem_addr !== 28'h1) begin bad++; $display("FAIL fetch_mem_addr got=%h exp=1", mem_addr); end
    total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL fetch_misses got=%0d exp=1", miss_count); end
    tick();
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL fetch_wait_stall got=%b exp=1", proc_stall); end
    mem_respond(LINE_A); #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL replay_stall got=%b exp=0", proc_stall); end
    total++; if (proc_rdata !== 32'hAAAA_AAAA) begin bad++; $display("FAIL replay_rdata got=%h exp=aaaaaaaa", proc_rdata); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL replay_mem_read got=%b exp=0", mem_read); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL replay_hits_before got=%0d exp=0", hit_count); end
  endtask

  task automatic test_seq_hits();
    logic [31:0] exp_words [3];
    exp_words[0] = 32'hBBBB_BBBB; exp_words[1] = 32'hCCCC_CCCC; exp_words[2] = 32'hDDDD_DDDD;
    for (int i = 0; i < 3; i++) begin
      tick();
      proc_addr = 30'h5 + 30'(i); #1;
      total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL seq_stall[%0d] got=%b exp=0", i, proc_stall); end
      total++; if (proc_rdata !== exp_words[i]) begin bad++; $display("FAIL seq_rdata[%0d] got=%h exp=%h", i, proc_rdata, exp_words[i]); end
      total++; if (hit_count !== 32'(i + 1)) begin bad++; $display("FAIL seq_hits[%0d] got=%0d exp=%0d", i, hit_count, i + 1); end
    end
    tick();
    proc_read = 1'b0; #1;
    total++; if (hit_count !== 32'd4) begin bad++; $display("FAIL seq_hits_final got=%0d exp=4", hit_count); end
    total++; if (proc_rdata !== 32'h0) begin bad++; $display("FAIL idle_rdata got=%h exp=0", proc_rdata); end
  endtask

  task automatic test_conflict();
    proc_read = 1'b1; proc_addr = 30'h24; #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL conflict_stall got=%b exp=1", proc_stall); end
    tick();
    total++; if (mem_addr !== 28'h9) begin bad++; $display("FAIL conflict_mem_addr got=%h exp=9", mem_addr); end
    total++; if (miss_count !== 32'd2) begin bad++; $display("FAIL conflict_misses got=%0d exp=2", miss_count); end
    mem_respond(LINE_B); #1;
    total++; if (proc_rdata !== 32'h2424_0000) begin bad++; $display("FAIL conflict_rdata got=%h exp=24240000", proc_rdata); end
    tick();
    proc_addr = 30'h4; #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL evicted_stall got=%b exp=1", proc_stall); end
    tick();
    total++; if (mem_addr !== 28'h1) begin bad++; $display("FAIL evicted_mem_addr got=%h exp=1", mem_addr); end
    total++; if (miss_count !== 32'd3) begin bad++; $display("FAIL evicted_misses got=%0d exp=3", miss_count); end
    mem_respond(LINE_A); #1;
    total++; if (proc_rdata !== 32'hAAAA_AAAA) begin bad++; $display("FAIL refill_rdata got=%h exp=aaaaaaaa", proc_rdata); end
    tick();
    proc_read = 1'b0; #1;
    total++; if (hit_count !== 32'd6) begin bad++; $display("FAIL conflict_hits got=%0d exp=6", hit_count); end
  endtask

  task automatic test_fill_completes();
    proc_read = 1'b1; proc_addr = 30'h24;
    tick();
    mem_respond(LINE_B);
    proc_addr = 30'h4;
    tick();
    proc_read = 1'b0; proc_addr = 30'h40; #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL hold_stall got=%b exp=1", proc_stall); end
    tick();
    total++; if (mem_addr !== 28'h1) begin bad++; $display("FAIL hold_mem_addr got=%h exp=1", mem_addr); end
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL hold_mem_read got=%b exp=1", mem_read); end
    mem_respond(LINE_C); #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL done_mem_read got=%b exp=0", mem_read); end
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL done_stall got=%b exp=0", proc_stall); end
    proc_read = 1'b1; proc_addr = 30'h6; #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL landed_stall got=%b exp=0", proc_stall); end
    total++; if (proc_rdata !== 32'hC0DE_0002) begin bad++; $display("FAIL landed_rdata got=%h exp=c0de0002", proc_rdata); end
    tick();
    proc_addr = 30'h40; #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL new_miss_stall got=%b exp=1", proc_stall); end
    tick();
    total++; if (mem_addr !== 28'h10) begin bad++; $display("FAIL new_miss_mem_addr got=%h exp=10", mem_addr); end
    total++; if (miss_count !== 32'd6) begin bad++; $display("FAIL new_miss_misses got=%0d exp=6", miss_count); end
    total++; if (hit_count !== 32'd7) begin bad++; $display("FAIL new_miss_hits got=%0d exp=7", hit_count); end
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1; proc_read = 1'b0;
    tick();
    rst = 1'b0; #1;
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL rst_fetch_mem_read got=%b exp=0", mem_read); end
    total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL rst_fetch_hits got=%0d exp=0", hit_count); end
    total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL rst_fetch_misses got=%0d exp=0", miss_count); end
    proc_read = 1'b1; proc_addr = 30'h6; #1;
    total++; if (proc_stall !== 1'b1) begin bad++; $display("FAIL rst_invalidates got=%b exp=1", proc_stall); end
    tick();
    total++; if (mem_addr !== 28'h1) begin bad++; $display("FAIL rst_refill_addr got=%h exp=1", mem_addr); end
    mem_respond(LINE_A);
    proc_read = 1'b0;
    mem_respond(LINE_C);
    proc_read = 1'b1; proc_addr = 30'h4; #1;
    total++; if (proc_rdata !== 32'hAAAA_AAAA) begin bad++; $display("FAIL idle_ready_ignored got=%h exp=aaaaaaaa", proc_rdata); end
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL idle_ready_mem_read got=%b exp=0", mem_read); end
    tick();
    proc_read = 1'b0; #1;
    total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL rst_hits got=%0d exp=1", hit_count); end
  endtask

  task automatic test_write_ignored();
    proc_write = 1'b1; proc_read = 1'b0; proc_addr = 30'h7FC; proc_wdata = 32'h1234_5678; #1;
    total++; if (proc_stall !== 1'b0) begin bad++; $display("FAIL write_stall got=%b exp=0", proc_stall); end
    tick(); tick();
    total++; if (mem_read !== 1'b0) begin bad++; $display("FAIL write_mem_read got=%b exp=0", mem_read); end
    total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL write_hits got=%0d exp=1", hit_count); end
    total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL write_misses got=%0d exp=1", miss_count); end
    total++; if (proc_rdata !== 32'h0) begin bad++; $display("FAIL write_rdata got=%h exp=0", proc_rdata); end
    proc_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_seq_hits();
    test_conflict();
    test_fill_completes();
    test_reset_mid_fetch();
    test_write_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
